// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer rectangle writer: screen defaults,
// FSM state encoding and pixel packing.
package fb_pkg;

  localparam int H_RES_DEF     = 640;
  localparam int V_RES_DEF     = 480;
  localparam int BYTES_PER_PIX = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    WRITE    = 3'd2,
    NEXT_ROW = 3'd3,
    DONE     = 3'd4
  } state_t;

  function automatic logic [31:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {8'h00, r, g, b};
  endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clipper: exclusive right/bottom bounds, empty flag and the
// byte address of the rectangle's top-left pixel.
module fb_rect_clip
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'h0000_0000,
  parameter int          H_RES   = H_RES_DEF,
  parameter int          V_RES   = V_RES_DEF,
  parameter int          ADDR_W  = 27
) (
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [9:0]        w,
  input  logic [9:0]        h,
  output logic [10:0]       x1,
  output logic [10:0]       y1,
  output logic              empty,
  output logic [ADDR_W-1:0] start_addr
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic [31:0] byte_addr;

  // Sums are one bit wider than the operands so 1023+1023 cannot wrap.
  always_comb begin
    x_end     = {1'b0, x} + {1'b0, w};
    y_end     = {1'b0, y} + {1'b0, h};
    x1        = (x_end > H_LIM) ? H_LIM : x_end;
    y1        = (y_end > V_LIM) ? V_LIM : y_end;
    empty     = (w == 10'd0) || (h == 10'd0) || ({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM);
    byte_addr = FB_BASE + (32'(y) * 32'(H_RES) + 32'(x)) * 32'(BYTES_PER_PIX);
    start_addr = byte_addr[ADDR_W-1:0];
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Avalon-MM write master filling clipped single-colour rectangles into the
// framebuffer. Define FB_OUTLINE_EN to add cmd_outline (border-only drawing).
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'h0000_0000,
  parameter int          H_RES   = H_RES_DEF,
  parameter int          V_RES   = V_RES_DEF,
  parameter int          ADDR_W  = 27
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_x,
  input  logic [9:0]        cmd_y,
  input  logic [9:0]        cmd_w,
  input  logic [9:0]        cmd_h,
  input  logic [23:0]       cmd_color,
`ifdef FB_OUTLINE_EN
  input  logic              cmd_outline,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES * BYTES_PER_PIX);
  localparam logic [ADDR_W-1:0] PIX_STEP = ADDR_W'(BYTES_PER_PIX);

  state_t            state, state_nxt;
  logic              ready_en;
  logic [9:0]        x0, y0, w_q, h_q;
  logic [9:0]        col, row;
  logic [ADDR_W-1:0] row_addr;
  logic [10:0]       x1, y1;
  logic              empty;
  logic [ADDR_W-1:0] start_addr;
  logic              beat_ok, last_col, last_row, skip_mid;
  logic [10:0]       col_next;
`ifdef FB_OUTLINE_EN
  logic              outline_q;
`endif

  fb_rect_clip #(
    .FB_BASE(FB_BASE),
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_clip (
    .x         (x0),
    .y         (y0),
    .w         (w_q),
    .h         (h_q),
    .x1        (x1),
    .y1        (y1),
    .empty     (empty),
    .start_addr(start_addr)
  );

  assign avm_byteenable = 4'hF;
  assign beat_ok        = (state == WRITE) && !avm_waitrequest;
  assign last_col       = ({1'b0, col} == x1 - 11'd1);
  assign last_row       = ({1'b0, row} == y1 - 11'd1);

  // Middle rows of an outline jump straight from the left to the right edge.
`ifdef FB_OUTLINE_EN
  assign skip_mid = outline_q && (row != y0) && !last_row && (col == x0);
`else
  assign skip_mid = 1'b0;
`endif
  assign col_next = skip_mid ? (x1 - 11'd1) : ({1'b0, col} + 11'd1);

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    avm_write = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = ready_en;
        if (cmd_valid && ready_en) state_nxt = SETUP;
      end
      SETUP:    state_nxt = empty ? DONE : WRITE;
      WRITE: begin
        avm_write = 1'b1;
        if (beat_ok && last_col) state_nxt = last_row ? DONE : NEXT_ROW;
      end
      NEXT_ROW: state_nxt = WRITE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      ready_en      <= 1'b0;
      x0            <= '0;
      y0            <= '0;
      w_q           <= '0;
      h_q           <= '0;
      col           <= '0;
      row           <= '0;
      row_addr      <= '0;
      avm_address   <= '0;
      avm_writedata <= '0;
`ifdef FB_OUTLINE_EN
      outline_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ready_en <= 1'b1;
      case (state)
        IDLE: if (cmd_valid && ready_en) begin
          x0            <= cmd_x;
          y0            <= cmd_y;
          w_q           <= cmd_w;
          h_q           <= cmd_h;
          avm_writedata <= pack_rgb(cmd_color[23:16], cmd_color[15:8], cmd_color[7:0]);
`ifdef FB_OUTLINE_EN
          outline_q     <= cmd_outline;
`endif
        end
        SETUP: begin
          col         <= x0;
          row         <= y0;
          row_addr    <= start_addr;
          avm_address <= start_addr;
        end
        WRITE: if (beat_ok && !last_col) begin
          col         <= col_next[9:0];
          avm_address <= avm_address + ADDR_W'(col_next - {1'b0, col}) * PIX_STEP;
        end
        NEXT_ROW: begin
          row         <= row + 10'd1;
          col         <= x0;
          row_addr    <= row_addr + ROW_STEP;
          avm_address <= row_addr + ROW_STEP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: a raster-order model of expected
// beats, a per-cycle compare process, directed edge cases and random commands.
module tb_fb_rect_writer;

  localparam int          H    = 640;
  localparam int          V    = 480;
  localparam int          AW   = 27;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          CLOCK_50 = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [9:0]    cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [23:0]   cmd_color = '0;
  logic          cmd_outline = 1'b0;
  logic          busy, done;
  logic [AW-1:0] avm_address;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic [3:0]    avm_byteenable;
  logic          avm_waitrequest = 1'b0;

  fb_rect_writer #(.FB_BASE(BASE), .H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .CLOCK_50       (CLOCK_50),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_x          (cmd_x),
    .cmd_y          (cmd_y),
    .cmd_w          (cmd_w),
    .cmd_h          (cmd_h),
    .cmd_color      (cmd_color),
`ifdef FB_OUTLINE_EN
    .cmd_outline    (cmd_outline),
`endif
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_pct = 0;

  // Model state
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  bit            in_cmd = 1'b0;
  bit            seen_edge = 1'b0;
  int            done_at = -1;
  int            acc_cyc = 0, done_cyc = 0, write_cycles = 0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected beats in raster order over the clipped rectangle.
  task automatic model_cmd(input int x, input int y, input int w, input int h,
                           input logic [23:0] c, input bit ol);
    int x1, y1;
    logic [31:0] a;
`ifndef FB_OUTLINE_EN
    ol = 1'b0;
`endif
    x1 = (x + w < H) ? x + w : H;
    y1 = (y + h < V) ? y + h : V;
    if (w == 0 || h == 0 || x >= H || y >= V) return;
    for (int r = y; r < y1; r++)
      for (int cc = x; cc < x1; cc++)
        if (!ol || r == y || r == y1 - 1 || cc == x || cc == x1 - 1) begin
          a = BASE + 32'((r * H + cc) * 4);
          exp_addr.push_back(a[AW-1:0]);
          exp_data.push_back({8'h00, c});
        end
  endtask

  always @(posedge CLOCK_50) begin
    cyc++;
    seen_edge = !rst;
  end

  always @(negedge CLOCK_50) begin : compare
    bit exp_ready, exp_done;
    if (rst) begin
      exp_addr.delete();
      exp_data.delete();
      in_cmd     = 1'b0;
      done_at    = -1;
      prev_stall = 1'b0;
      seen_edge  = 1'b0;
    end else begin
      exp_ready = seen_edge && !in_cmd;
      exp_done  = (cyc == done_at);
      check("cmd_ready", cmd_ready, exp_ready);
      check("busy", busy, in_cmd);
      check("done", done, exp_done);
      if (prev_stall) begin
        check("stall_write", avm_write, 1);
        check("stall_addr", avm_address, prev_addr);
        check("stall_data", avm_writedata, prev_data);
      end
      if (exp_addr.size() == 0) check("no_write_expected", avm_write, 0);
      if (avm_write) begin
        write_cycles++;
        check("byteenable", avm_byteenable, 4'hF);
        if (!avm_waitrequest && exp_addr.size() > 0) begin
          check("beat_addr", avm_address, exp_addr.pop_front());
          check("beat_data", avm_writedata, exp_data.pop_front());
          log_addr.push_back(avm_address);
          log_data.push_back(avm_writedata);
          if (exp_addr.size() == 0) done_at = cyc + 1;
        end
      end
      prev_stall = avm_write && avm_waitrequest;
      prev_addr  = avm_address;
      prev_data  = avm_writedata;
      if (cmd_valid && exp_ready) begin
        acc_cyc      = cyc;
        write_cycles = 0;
        log_addr.delete();
        log_data.delete();
        model_cmd(int'(cmd_x), int'(cmd_y), int'(cmd_w), int'(cmd_h), cmd_color, cmd_outline);
        if (exp_addr.size() == 0) done_at = cyc + 2;
        in_cmd = 1'b1;
      end
      if (exp_done) begin
        in_cmd   = 1'b0;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLOCK_50);
      #1 avm_waitrequest = ($urandom_range(0, 99) < stall_pct);
    end
  end

  task automatic issue(input int x, input int y, input int w, input int h,
                       input logic [23:0] c, input bit ol);
    bit accepted = 1'b0;
    @(posedge CLOCK_50);
    #1;
    cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
    cmd_color = c; cmd_outline = ol; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (cmd_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge CLOCK_50);
    #1 cmd_valid = 1'b0;
    check("accept_timeout", accepted, 1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge CLOCK_50);
      #1 n++;
    end while (in_cmd && n < budget);
    check("done_timeout", in_cmd, 0);
    check("beats_left", exp_addr.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (5) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", avm_write, 0);
    check("rst_addr", avm_address, 0);
    check("rst_data", avm_writedata, 0);
    @(posedge CLOCK_50);
    #1 rst = 1'b0;
    @(posedge CLOCK_50);
    #1 check("ready_after_rst", cmd_ready, 1);

    // Basic 2x2 fill
    issue(0, 0, 2, 2, 24'hFF0000, 0);
    wait_done(500);
    check("fill_n_beats", log_addr.size(), 4);
    check("fill_addr0", log_addr[0], 27'h0);
    check("fill_addr1", log_addr[1], 27'h4);
    check("fill_addr2", log_addr[2], 27'hA00);
    check("fill_addr3", log_addr[3], 27'hA04);
    check("fill_data", log_data[3], 32'h00FF_0000);
    check("fill_cycles", done_cyc - acc_cyc + 1, 8);
    check("fill_done_lat", done_cyc - acc_cyc, 7);

    // Bottom-right clipping
    issue(638, 479, 10, 10, 24'h12_34_56, 0);
    wait_done(500);
    check("clip_n_beats", log_addr.size(), 2);
    check("clip_addr0", log_addr[0], 27'h12BFF8);
    check("clip_addr1", log_addr[1], 27'h12BFFC);

    // Empty commands
    issue(5, 5, 0, 7, 24'h00FF00, 0);
    wait_done(500);
    check("empty_w_writes", write_cycles, 0);
    check("empty_w_done_lat", done_cyc - acc_cyc, 2);
    issue(640, 10, 4, 4, 24'h00FF00, 0);
    wait_done(500);
    check("empty_x_writes", write_cycles, 0);
    check("empty_x_done_lat", done_cyc - acc_cyc, 2);

    // Stalls
    stall_pct = 50;
    issue(100, 50, 4, 3, 24'hABCDEF, 0);
    wait_done(2000);
    check("stall_n_beats", log_addr.size(), 12);
    stall_pct = 0;

    // Command offered while busy must be ignored
    issue(10, 10, 6, 4, 24'h0000FF, 0);
    @(posedge CLOCK_50);
    #1;
    cmd_x = 10'd300; cmd_y = 10'd300; cmd_w = 10'd3; cmd_h = 10'd3; cmd_valid = 1'b1;
    repeat (8) @(posedge CLOCK_50);
    #1 cmd_valid = 1'b0;
    wait_done(2000);
    check("busy_cmd_beats", log_addr.size(), 24);

    // Reset in the middle of a burst
    issue(20, 20, 8, 8, 24'h808080, 0);
    for (int i = 0; i < 200 && log_addr.size() < 3; i++) @(negedge CLOCK_50);
    check("third_beat_seen", log_addr.size(), 3);
    @(posedge CLOCK_50);
    #2 rst = 1'b1;
    #1;
    check("midrst_write", avm_write, 0);
    check("midrst_busy", busy, 0);
    check("midrst_addr", avm_address, 0);
    repeat (3) @(posedge CLOCK_50);
    #1 rst = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    issue(1, 2, 3, 2, 24'h010203, 0);
    wait_done(500);
    check("post_rst_beats", log_addr.size(), 6);

`ifdef FB_OUTLINE_EN
    issue(200, 100, 4, 4, 24'hFFFFFF, 1);
    wait_done(500);
    check("outline_beats", log_addr.size(), 12);
`endif

    // Random commands
    for (int k = 0; k < 30; k++) begin
      int x, y, w, h;
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(620, 700) : $urandom_range(0, 639);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(470, 500) : $urandom_range(0, 479);
      w = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, 12);
      h = $urandom_range(0, 6);
      if (w == 1023) x = ($urandom_range(0, 1) == 0) ? 1023 : $urandom_range(625, 639);
      stall_pct = $urandom_range(0, 60);
      issue(x, y, w, h, 24'($urandom), 1'($urandom_range(0, 1)));
      wait_done(5000);
    end
    stall_pct = 0;

    repeat (3) @(posedge CLOCK_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
